// File: rtl/rr_arb_eight.sv
// rr_arb_eight: eight-way round-robin arbiter with a hold limit.
//
// Each grant is held for at most MAX_HOLD consecutive cycles while other
// requesters are waiting, then it rotates to the next requester. All outputs
// come straight from registers.
//
// Ports:
//   clk      - system clock; state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   enab     - allows new grants and preemption
//   req      - request lines, one per requester
//   gnt      - one-hot grant vector, all-zero when idle
//   gnt_idx  - binary index of the current (or most recent) owner
//   gnt_vld  - high while a grant is active
module rr_arb_eight #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enab,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state;
  logic [2:0] r_lp;
  logic [7:0] r_hc;
  logic [2:0] r_gntIdx;
  logic       r_gntVld;
  logic [7:0] r_gnt;

  logic [7:0] w_selMask;
  logic [2:0] w_selIdx;
  logic       w_selFound;
  logic [2:0] w_cand;

  // While granting, the current owner is masked out so the search only finds
  // other requesters. On a release its request bit is already low, and on a
  // timeout it must be excluded, so one mask serves both cases.
  always_comb begin
    w_selMask = req;
    if (r_state == GRANT) begin
      w_selMask = req & ~(8'b1 << r_gntIdx);
    end
  end

  // Rotating-priority search starting one past the last owner; the 3-bit
  // addition wraps 7 -> 0, so the last owner itself is examined last.
  always_comb begin
    w_selIdx   = r_lp;
    w_selFound = 1'b0;
    w_cand     = r_lp;
    for (int k = 1; k <= 8; k++) begin
      w_cand = r_lp + 3'(k);
      if (!w_selFound && w_selMask[w_cand]) begin
        w_selIdx   = w_cand;
        w_selFound = 1'b1;
      end
    end
  end

  // The hold counter saturates at MAX_HOLD, so a lone owner can keep the
  // grant indefinitely and still be preempted as soon as a competitor shows
  // up. A release always wins over a simultaneous timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lp     <= 3'd7;
      r_hc     <= 8'd0;
      r_gntIdx <= 3'd0;
      r_gntVld <= 1'b0;
      r_gnt    <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enab && w_selFound) begin
            r_state  <= GRANT;
            r_gntIdx <= w_selIdx;
            r_lp     <= w_selIdx;
            r_hc     <= 8'd1;
            r_gntVld <= 1'b1;
            r_gnt    <= 8'b1 << w_selIdx;
          end
        end
        GRANT: begin
          if (!req[r_gntIdx]) begin
            if (enab && w_selFound) begin
              r_gntIdx <= w_selIdx;
              r_lp     <= w_selIdx;
              r_hc     <= 8'd1;
              r_gnt    <= 8'b1 << w_selIdx;
            end else begin
              r_state  <= IDLE;
              r_gntVld <= 1'b0;
              r_gnt    <= 8'd0;
            end
          end else if (r_hc < 8'(MAX_HOLD)) begin
            r_hc <= r_hc + 8'd1;
          end else if (enab && w_selFound) begin
            r_gntIdx <= w_selIdx;
            r_lp     <= w_selIdx;
            r_hc     <= 8'd1;
            r_gnt    <= 8'b1 << w_selIdx;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_gntVld <= 1'b0;
          r_gnt    <= 8'd0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gntIdx;
  assign gnt_vld = r_gntVld;

endmodule

// File: doc/rr_arb_eight.md
RR_ARB_EIGHT -- requirements
Module: rr_arb_eight

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum consecutive grant cycles before forced rotation when other requests are pending; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enab  input  1  enabler; permits issue of new grants.
REQ-005 req  input  8  request lines; req[i] high = requester i wants the shared resource.
REQ-006 gnt  output  8  one-hot grant, gnt[i] high = requester i owns resource; all-zero when idle.
REQ-007 gnt_idx  output  3  binary index of current owner; held at last owner when idle.
REQ-008 gnt_vld  output  1  high while any grant is active.

Function
REQ-009 All outputs SHALL be registered; gnt SHALL equal the 3-to-8 decode of gnt_idx gated by gnt_vld at every cycle.
REQ-010 Internal state: FSM {IDLE, GRANT}, 3-bit last-owner pointer lp, 8-bit hold counter hc.
REQ-011 Selection: next owner = first i with req[i]=1 searching lp+1, lp+2, ... mod 8 (wrap 7->0), lp itself checked last.
REQ-012 IDLE: if enab=1 and req!=0, next cycle -> GRANT, gnt_idx=selected i, gnt_vld=1, lp=i, hc=1; else stay IDLE, gnt_vld=0.
REQ-013 Grant latency: request sampled at edge N appears as gnt at edge N+1 (one cycle).
REQ-014 GRANT, release: if req[gnt_idx]=0, owner releases; if enab=1 and another request exists, next cycle grants that requester (zero-bubble handoff, hc=1); else next cycle -> IDLE, gnt=0.
REQ-015 GRANT, hold: if req[gnt_idx]=1 and hc<MAX_HOLD, keep grant, hc increments.
REQ-016 GRANT, timeout: if req[gnt_idx]=1, hc=MAX_HOLD, enab=1 and any other req bit high, SHALL preempt to next requester per REQ-011 excluding current owner, hc=1.
REQ-017 Timeout with no other requester: grant retained, hc saturates at MAX_HOLD (no wrap).
REQ-018 enab=0 during GRANT: current owner keeps grant until release or timeout; no new grant or preemption issued; on release go to IDLE.
REQ-019 Simultaneous release and timeout: release takes priority (REQ-014).
REQ-020 Requester dropping req in same cycle as being selected in IDLE: selection uses sampled req; grant issued, then released next cycle per REQ-014.
REQ-021 Exactly zero or one gnt bit SHALL be high in every cycle; gnt never asserted to a requester whose req was low at the selecting edge.
REQ-022 Starvation bound: any held request SHALL be granted within 7*MAX_HOLD+1 cycles while enab=1.

Reset
REQ-023 rst_n low SHALL immediately (asynchronously) force: FSM=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, hc=0, lp=7 (first search starts at requester 0).
REQ-024 Reset mid-grant SHALL drop grant without waiting for clk; after rst_n deassert first grant follows REQ-012 from lp=7.
REQ-025 rst_n deassertion SHALL be treated as synchronous release; no grant in the first edge at which rst_n is sampled low.

Verification
REQ-026 Post-reset, enab=1, req=8'h81 -> next cycle gnt=8'h01, gnt_idx=0; drop req[0] -> next cycle gnt=8'h80, gnt_idx=7 (no bubble).
REQ-027 req=8'hFF constant, MAX_HOLD=15 -> grants rotate 0,1,...,7,0, each held exactly 15 cycles; gnt always one-hot.
REQ-028 req=8'h10 only, held 40 cycles -> gnt=8'h10 continuous, no gap, hc saturates at 15; drop req -> next cycle gnt=0, gnt_vld=0.
REQ-029 Owner 2 holding, enab driven 0, req=8'h0C for 30 cycles -> grant stays on 2 (no preemption); enab=1 -> next cycle after timeout check gnt=8'h08.
REQ-030 rst_n pulled low mid-grant between clock edges -> gnt=0 and gnt_vld=0 before next edge; after release with req=8'h20 -> gnt=8'h20 one cycle after first enabled edge.
REQ-031 Random req/enab stress, 10k cycles -> assert REQ-009, REQ-021, REQ-022 every cycle.
